// File: rtl/tiled_array_controller.sv
// Job sequencer for an N x N systolic PE array: per tile it stages weights and
// activations from shared SRAM, streams them through the array, drains results, then writes back.
module tiled_array_controller #(
   parameter int N      = 16,
   parameter int ADDR_W = 13,
   parameter int TILE_W = 6
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              MODE,
   input  logic [TILE_W-1:0] TILES,
   input  logic [ADDR_W-1:0] IADDR,
   input  logic [ADDR_W-1:0] WADDR,
   input  logic [ADDR_W-1:0] OADDR,
   output logic              BUSY,
   output logic              DONE,
   output logic [2:0]        STATE,
   output logic              W_EN,
   output logic              SELECTOR,
   output logic              ACC_CLR,
   output logic              share_cen,
   output logic              share_wen,
   output logic [ADDR_W-1:0] share_addr,
   output logic              weight_cen,
   output logic              weight_wen,
   output logic [ADDR_W-1:0] weight_addr,
   output logic              activate_cen,
   output logic              activate_wen,
   output logic [ADDR_W-1:0] activate_addr,
   output logic              output_cen,
   output logic              output_wen,
   output logic [ADDR_W-1:0] output_addr
);

   // Counter must hold the longest phase: write-back of N*(2^TILE_W - 1) words.
   localparam int CNT_W = $clog2(N * (1 << TILE_W) + 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOADW = 3'd1,
      S_LOADA = 3'd2,
      S_CALC  = 3'd3,
      S_DRAIN = 3'd4,
      S_WB    = 3'd5,
      S_FIN   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    last_cnt;
   logic                state_done;
   logic [TILE_W-1:0]   tile_q;
   logic [TILE_W-1:0]   tiles_q;
   logic [TILE_W-1:0]   tiles_eff;
   logic                tile_last;
   logic                mode_q;
   logic [ADDR_W-1:0]   iaddr_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [ADDR_W-1:0]   oaddr_q;
   logic [ADDR_W-1:0]   tile_off_q;
   logic [CNT_W-1:0]    wb_len_q;
   logic [CNT_W-1:0]    wb_len_d;
   logic [ADDR_W-1:0]   cnt_a;
   logic [ADDR_W-1:0]   cnt_m1;
   logic [ADDR_W-1:0]   drain_off;
   logic                rd_phase;
   logic                wr_phase;

   assign tiles_eff  = (TILES == '0) ? TILE_W'(1) : TILES;
   assign wb_len_d   = MODE ? CNT_W'(N) : CNT_W'(N) * CNT_W'(tiles_eff);
   assign tile_last  = (tile_q == tiles_q - TILE_W'(1));
   assign cnt_a      = ADDR_W'(cnt_q);
   assign cnt_m1     = ADDR_W'(cnt_q - CNT_W'(1));
   assign drain_off  = ADDR_W'(cnt_q - CNT_W'(N));
   assign rd_phase   = (cnt_q < CNT_W'(N));
   assign wr_phase   = (cnt_q != '0);
   assign state_done = (cnt_q == last_cnt);

   // Handshake: START is a one-cycle request honoured only in IDLE; BUSY spans
   // LOADW..WB, and DONE pulses for the single FIN cycle with BUSY already low.
   always_comb begin
      last_cnt = '0;
      state_d  = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_LOADW;
         S_LOADW: begin
            last_cnt = CNT_W'(N);
            if (state_done) state_d = S_LOADA;
         end
         S_LOADA: begin
            last_cnt = CNT_W'(N);
            if (state_done) state_d = S_CALC;
         end
         S_CALC: begin
            last_cnt = CNT_W'(N - 1);
            if (state_done) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            last_cnt = CNT_W'(2 * N - 1);
            if (state_done) state_d = tile_last ? S_WB : S_LOADW;
         end
         S_WB: begin
            last_cnt = wb_len_q;
            if (state_done) state_d = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tile_q     <= '0;
         tiles_q    <= '0;
         mode_q     <= 1'b0;
         iaddr_q    <= '0;
         waddr_q    <= '0;
         oaddr_q    <= '0;
         tile_off_q <= '0;
         wb_len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= state_done ? '0 : cnt_q + CNT_W'(1);
         if (state_q == S_IDLE && START) begin
            mode_q     <= MODE;
            tiles_q    <= tiles_eff;
            iaddr_q    <= IADDR;
            waddr_q    <= WADDR;
            oaddr_q    <= OADDR;
            tile_q     <= '0;
            tile_off_q <= '0;
            wb_len_q   <= wb_len_d;
         end else if (state_q == S_DRAIN && state_done && !tile_last) begin
            tile_q     <= tile_q + TILE_W'(1);
            tile_off_q <= tile_off_q + ADDR_W'(N);
         end
      end
   end

   // Writes trail reads by one cycle to cover the 1-cycle SRAM read latency.
   always_comb begin
      W_EN          = 1'b0;
      SELECTOR      = 1'b0;
      ACC_CLR       = 1'b0;
      DONE          = 1'b0;
      share_cen     = 1'b1;
      share_wen     = 1'b1;
      share_addr    = '0;
      weight_cen    = 1'b1;
      weight_wen    = 1'b1;
      weight_addr   = '0;
      activate_cen  = 1'b1;
      activate_wen  = 1'b1;
      activate_addr = '0;
      output_cen    = 1'b1;
      output_wen    = 1'b1;
      output_addr   = '0;
      case (state_q)
         S_LOADW: begin
            if (rd_phase) begin
               share_cen  = 1'b0;
               share_addr = waddr_q + tile_off_q + cnt_a;
            end
            if (wr_phase) begin
               weight_cen  = 1'b0;
               weight_wen  = 1'b0;
               weight_addr = cnt_m1;
            end
         end
         S_LOADA: begin
            if (rd_phase) begin
               share_cen   = 1'b0;
               share_addr  = iaddr_q + tile_off_q + cnt_a;
               weight_cen  = 1'b0;
               weight_addr = cnt_a;
               W_EN        = 1'b1;
               SELECTOR    = 1'b1;
            end
            if (wr_phase) begin
               activate_cen  = 1'b0;
               activate_wen  = 1'b0;
               activate_addr = cnt_m1;
            end
         end
         S_CALC: begin
            activate_cen  = 1'b0;
            activate_addr = cnt_a;
            ACC_CLR       = (cnt_q == '0) && (!mode_q || tile_q == '0);
         end
         S_DRAIN: begin
            if (!rd_phase) begin
               output_cen  = 1'b0;
               output_wen  = 1'b0;
               output_addr = (mode_q ? '0 : tile_off_q) + drain_off;
            end
         end
         S_WB: begin
            if (cnt_q < wb_len_q) begin
               output_cen  = 1'b0;
               output_addr = cnt_a;
            end
            if (wr_phase) begin
               share_cen  = 1'b0;
               share_wen  = 1'b0;
               share_addr = oaddr_q + cnt_m1;
            end
         end
         S_FIN:   DONE = 1'b1;
         default: ;
      endcase
   end

   assign BUSY  = (state_q != S_IDLE) && (state_q != S_FIN);
   assign STATE = state_q;

endmodule
